// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754-style multiplier (EXP_W/MAN_W generic) with
// five rounding modes, DAZ/FTZ handling and per-result exception flags.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] fp_X,
    input  logic [W-1:0] fp_Y,
    input  logic [2:0]   r_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] fp_Z,
    output logic         ovrf,
    output logic         undrf,
    output logic         invld,
    output logic         inxct
);

    localparam int PW = 2 * MAN_W + 2;
    localparam int XW = EXP_W + 2;
    localparam logic [XW-1:0] BIAS    = XW'(2 ** (EXP_W - 1) - 1);
    localparam logic [XW-1:0] EXP_MAX = XW'(2 ** EXP_W - 1);
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    // Valid/ready: a word moves on valid&ready at the rising edge; a stage loads
    // when it is empty or its successor loads, so in_ready never sees in_valid.
    logic s1_valid, s2_valid, s3_valid;
    logic s1_en, s2_en, s3_en;

    assign s3_en     = !s3_valid || out_ready;
    assign s2_en     = !s2_valid || s3_en;
    assign s1_en     = !s1_valid || s2_en;
    assign in_ready  = s1_en;
    assign out_valid = s3_valid;

    // ---------------- S1: unpack, classify, exponent sum, significand product
    logic [EXP_W-1:0] x_exp, y_exp;
    logic [MAN_W-1:0] x_frac, y_frac;
    logic             x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, x_snan, y_snan;
    logic [PW-1:0]    x_sig, y_sig;

    always_comb begin
        x_exp  = fp_X[W-2:MAN_W];
        y_exp  = fp_Y[W-2:MAN_W];
        x_frac = fp_X[MAN_W-1:0];
        y_frac = fp_Y[MAN_W-1:0];
        // Subnormals fall into the zero class (DAZ).
        x_zero = (x_exp == '0);
        y_zero = (y_exp == '0);
        x_inf  = (x_exp == '1) && (x_frac == '0);
        y_inf  = (y_exp == '1) && (y_frac == '0);
        x_nan  = (x_exp == '1) && (x_frac != '0);
        y_nan  = (y_exp == '1) && (y_frac != '0);
        x_snan = x_nan && !x_frac[MAN_W-1];
        y_snan = y_nan && !y_frac[MAN_W-1];
        x_sig  = PW'({1'b1, x_frac});
        y_sig  = PW'({1'b1, y_frac});
    end

    logic            s1_sign, s1_zero, s1_inf, s1_nan, s1_snan, s1_infzero;
    logic [XW-1:0]   s1_exp;
    logic [PW-1:0]   s1_prod;
    logic [2:0]      s1_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (s1_en) begin
            s1_valid   <= in_valid;
            s1_sign    <= fp_X[W-1] ^ fp_Y[W-1];
            s1_exp     <= XW'(x_exp) + XW'(y_exp) - BIAS;
            s1_prod    <= x_sig * y_sig;
            s1_zero    <= x_zero || y_zero;
            s1_inf     <= x_inf || y_inf;
            s1_nan     <= x_nan || y_nan;
            s1_snan    <= x_snan || y_snan;
            s1_infzero <= (x_inf && y_zero) || (y_inf && x_zero);
            s1_mode    <= r_mode;
        end
    end

    // ---------------- S2: normalise, round, renormalise
    logic             hi, g, r, s, inc, carry;
    logic [PW-1:0]    norm;
    logic [MAN_W:0]   mant;
    logic [MAN_W+1:0] mant_inc;
    logic [MAN_W-1:0] frac_r;
    logic [XW-1:0]    exp_r;

    always_comb begin
        hi   = s1_prod[PW-1];
        norm = hi ? s1_prod : {s1_prod[PW-2:0], 1'b0};
        mant = norm[PW-1:MAN_W+1];
        g    = norm[MAN_W];
        r    = norm[MAN_W-1];
        s    = |norm[MAN_W-2:0];
        inc  = g && (r || s || mant[0]);
        case (s1_mode)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = s1_sign && (g || r || s);
            RM_RUP:  inc = !s1_sign && (g || r || s);
            RM_RMM:  inc = g;
            default: inc = g && (r || s || mant[0]);
        endcase
        mant_inc = {1'b0, mant} + (MAN_W + 2)'(inc);
        carry    = mant_inc[MAN_W+1];
        frac_r   = carry ? mant_inc[MAN_W:1] : mant_inc[MAN_W-1:0];
        exp_r    = s1_exp + XW'(hi) + XW'(carry);
    end

    logic             s2_sign, s2_inexact, s2_zero, s2_inf, s2_nan, s2_snan, s2_infzero;
    logic [XW-1:0]    s2_exp;
    logic [MAN_W-1:0] s2_frac;
    logic [2:0]       s2_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else if (s2_en) begin
            s2_valid   <= s1_valid;
            s2_sign    <= s1_sign;
            s2_exp     <= exp_r;
            s2_frac    <= frac_r;
            s2_inexact <= g || r || s;
            s2_zero    <= s1_zero;
            s2_inf     <= s1_inf;
            s2_nan     <= s1_nan;
            s2_snan    <= s1_snan;
            s2_infzero <= s1_infzero;
            s2_mode    <= s1_mode;
        end
    end

    // ---------------- S3: special cases, overflow/underflow substitution, flags
    logic [W-1:0] z_d;
    logic         ovrf_d, undrf_d, invld_d, inxct_d, ovf, unf, to_inf;

    always_comb begin
        ovf     = !s2_exp[XW-1] && (s2_exp >= EXP_MAX);
        unf     = s2_exp[XW-1] || (s2_exp == '0);
        to_inf  = !((s2_mode == RM_RTZ) || (s2_mode == RM_RDN && !s2_sign) ||
                    (s2_mode == RM_RUP && s2_sign));
        z_d     = {s2_sign, s2_exp[EXP_W-1:0], s2_frac};
        ovrf_d  = 1'b0;
        undrf_d = 1'b0;
        invld_d = 1'b0;
        inxct_d = 1'b0;
        if (s2_nan || s2_infzero) begin
            z_d     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
            invld_d = s2_snan || s2_infzero;
        end else if (s2_inf) begin
            z_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s2_zero) begin
            z_d = {s2_sign, {(W - 1){1'b0}}};
        end else if (ovf) begin
            z_d     = to_inf ? {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                             : {s2_sign, {(EXP_W - 1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            ovrf_d  = 1'b1;
            inxct_d = 1'b1;
        end else if (unf) begin
            z_d     = {s2_sign, {(W - 1){1'b0}}};
            undrf_d = 1'b1;
            inxct_d = 1'b1;
        end else begin
            inxct_d = s2_inexact;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid <= 1'b0;
            fp_Z     <= '0;
            ovrf     <= 1'b0;
            undrf    <= 1'b0;
            invld    <= 1'b0;
            inxct    <= 1'b0;
        end else if (s3_en) begin
            s3_valid <= s2_valid;
            fp_Z     <= z_d;
            ovrf     <= ovrf_d;
            undrf    <= undrf_d;
            invld    <= invld_d;
            inxct    <= inxct_d;
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe: queued expected results popped by a monitor,
// plus a small-format instance and flow-control / reset checks.
module tb_fp_mul_pipe;

    localparam int W  = 32;
    localparam int EW = W + 4;
    localparam logic [2:0] RNE = 3'b000;
    localparam logic [2:0] RTZ = 3'b001;
    localparam logic [2:0] RDN = 3'b010;
    localparam logic [2:0] RUP = 3'b011;
    localparam logic [2:0] RMM = 3'b100;

    // ---------------- clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] fp_x, fp_y, fp_z;
    logic [2:0]   r_mode;
    logic         ovrf, undrf, invld, inxct;

    logic         in_valid5, in_ready5, out_valid5, out_ready5;
    logic [15:0]  x5, y5, z5;
    logic [2:0]   mode5;
    logic         ovrf5, undrf5, invld5, inxct5;

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fp_X(fp_x), .fp_Y(fp_y), .r_mode(r_mode), .out_valid(out_valid),
        .out_ready(out_ready), .fp_Z(fp_z), .ovrf(ovrf), .undrf(undrf),
        .invld(invld), .inxct(inxct)
    );

    fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) u_dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
        .fp_X(x5), .fp_Y(y5), .r_mode(mode5), .out_valid(out_valid5),
        .out_ready(out_ready5), .fp_Z(z5), .ovrf(ovrf5), .undrf(undrf5),
        .invld(invld5), .inxct(inxct5)
    );

    // ---------------- scoreboard state
    int n_checks = 0;
    int n_fail   = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- driver tasks
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2:0] m, input logic [W-1:0] z, input logic [3:0] f);
        int waited;
        waited = 0;
        @(negedge clk);
        fp_x = x;
        fp_y = y;
        r_mode = m;
        in_valid = 1'b1;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck low for x=0x%0h y=0x%0h", x, y);
        end else begin
            exp_q.push_back({z, f});
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- monitor: pops on each output transfer, checks hold while stalled
    logic [EW-1:0] mon_e;
    logic [W-1:0]  held_z;
    logic          held = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(fp_z), 64'(held_z));
            end
            if (out_valid && out_ready) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%0h with no result pending", fp_z);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("result", 64'({fp_z, ovrf, undrf, invld, inxct}), 64'(mon_e));
                end
            end else if (out_valid) begin
                held = 1'b1;
                held_z = fp_z;
            end else begin
                held = 1'b0;
            end
        end
    end

    // ---------------- stimulus
    int lat;
    int n5;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        fp_x = '0;
        fp_y = '0;
        r_mode = RNE;
        out_ready = 1'b1;
        in_valid5 = 1'b0;
        x5 = '0;
        y5 = '0;
        mode5 = RNE;
        out_ready5 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_z_flags", 64'({fp_z, ovrf, undrf, invld, inxct}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // latency: accept cycle counted as 1, out_valid expected in cycle 3 after it
        send(32'h3FC00000, 32'h40000000, RNE, 32'h40400000, 4'b0000);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'd3);
        drain("drain_latency");

        // directed vectors, back-to-back; flags are {ovrf,undrf,invld,inxct}
        send(32'h3F800001, 32'h3F800001, RNE, 32'h3F800002, 4'b0001);
        send(32'h3F800001, 32'h3F800001, RTZ, 32'h3F800002, 4'b0001);
        send(32'h3F800001, 32'h3F800001, RUP, 32'h3F800003, 4'b0001);
        send(32'hBF800001, 32'h3F800001, RDN, 32'hBF800003, 4'b0001);
        send(32'hBF800001, 32'h3F800001, RUP, 32'hBF800002, 4'b0001);
        send(32'h3F800003, 32'h3FC00000, RNE, 32'h3FC00004, 4'b0001);
        send(32'h3F800003, 32'h3FC00000, RMM, 32'h3FC00005, 4'b0001);
        send(32'h3F800003, 32'h3FC00000, 3'b110, 32'h3FC00004, 4'b0001);
        send(32'h3F800001, 32'h3FC00000, RTZ, 32'h3FC00001, 4'b0001);
        send(32'h3FB504F3, 32'h3FB504F3, RNE, 32'h3FFFFFFF, 4'b0001);
        send(32'h3FB504F3, 32'h3FB504F3, RUP, 32'h40000000, 4'b0001);
        send(32'h7F000000, 32'h40000000, RNE, 32'h7F800000, 4'b1001);
        send(32'h7F000000, 32'h40000000, RTZ, 32'h7F7FFFFF, 4'b1001);
        send(32'hFF000000, 32'h40000000, RUP, 32'hFF7FFFFF, 4'b1001);
        send(32'h7F000000, 32'h40000000, RDN, 32'h7F7FFFFF, 4'b1001);
        send(32'hFF000000, 32'h40000000, RDN, 32'hFF800000, 4'b1001);
        send(32'h00800000, 32'h3F000000, RNE, 32'h00000000, 4'b0101);
        send(32'h80800000, 32'h3F000000, RNE, 32'h80000000, 4'b0101);
        send(32'h7F800000, 32'h00000000, RNE, 32'h7FC00000, 4'b0010);
        send(32'h7FC00000, 32'h3F800000, RNE, 32'h7FC00000, 4'b0000);
        send(32'h7F800001, 32'h3F800000, RNE, 32'h7FC00000, 4'b0010);
        send(32'h7F800000, 32'hC0000000, RNE, 32'hFF800000, 4'b0000);
        send(32'h7F800000, 32'h7F800000, RTZ, 32'h7F800000, 4'b0000);
        send(32'h80000000, 32'h40000000, RNE, 32'h80000000, 4'b0000);
        send(32'h00000001, 32'hBF800000, RNE, 32'h80000000, 4'b0000);
        drain("drain_vectors");

        // backpressure: three accepted, the fourth held off until out_ready rises
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(32'h3F800000, 32'h3F800000, RNE, 32'h3F800000, 4'b0000);
        send(32'h40000000, 32'h40000000, RNE, 32'h40800000, 4'b0000);
        send(32'h3FC00000, 32'h3FC00000, RNE, 32'h40100000, 4'b0000);
        @(negedge clk);
        fp_x = 32'h40400000;
        fp_y = 32'h3F000000;
        r_mode = RNE;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("full_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(32'h40400000, 32'h3F000000, RNE, 32'h3FC00000, 4'b0000);
        send(32'hC0000000, 32'h40400000, RNE, 32'hC0C00000, 4'b0000);
        drain("drain_backpressure");

        // half-precision-like instance: 1.5 * 2.0 = 3.0
        @(negedge clk);
        x5 = 16'h3E00;
        y5 = 16'h4000;
        mode5 = RNE;
        in_valid5 = 1'b1;
        check("small_in_ready", 64'(in_ready5), 64'd1);
        @(posedge clk);
        #1 in_valid5 = 1'b0;
        n5 = 0;
        @(negedge clk);
        while (!out_valid5 && n5 < 10) begin
            @(negedge clk);
            n5++;
        end
        check("small_valid", 64'(out_valid5), 64'd1);
        check("small_result", 64'({z5, ovrf5, undrf5, invld5, inxct5}), 64'({16'h4200, 4'b0000}));

        // reset with two results in flight: neither may ever appear
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(32'h40000000, 32'h40000000, RNE, 32'h40800000, 4'b0000);
        send(32'h3F800000, 32'h3F800000, RNE, 32'h3F800000, 4'b0000);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_z", 64'(fp_z), 64'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst_idle", 64'(out_valid), 64'd0);

        send(32'h3FC00000, 32'h40000000, RNE, 32'h40400000, 4'b0000);
        drain("drain_after_reset");
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
